// File: rtl/lcu_pkg.sv
// Shared types and sizing helpers for the programmable logic control unit.
// Latency: none (declarations only).
// Backpressure: none.
package lcu_pkg;

  // Returns the index width for n entries, never narrower than one bit.
  function automatic int lcu_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Default geometry of the unit. The rule record below is sized from these,
  // so a different geometry is selected by editing these constants, and the
  // module parameters are overridden to the same values.
  localparam int LCU_N_IN     = 15;
  localparam int LCU_N_OUT    = 23;
  localparam int LCU_N_STATES = 22;
  localparam int LCU_RULES    = 8;
  localparam int LCU_SW       = lcu_clog2(LCU_N_STATES);
  localparam int LCU_RW       = lcu_clog2(LCU_RULES);

  // One transition rule: fires when enabled and x agrees with val on every
  // bit selected by mask.
  typedef struct packed {
    logic                 valid;
    logic [LCU_N_IN-1:0]  mask;
    logic [LCU_N_IN-1:0]  val;
    logic [LCU_SW-1:0]    next;
    logic [LCU_N_OUT-1:0] out;
  } rule_t;

endpackage

// File: rtl/lcu_prog_if.sv
// Bundle of run control, condition inputs, rule-write bus and status outputs.
// Latency: none (wiring only).
// Backpressure: none; the rule-write bus is a single-cycle strobe.
// Ports: master drives run/x/cfg_*, slave (the unit) drives y/state/
// trans_cnt/wdog_trip/cfg_err.
interface lcu_prog_if
  import lcu_pkg::*;
#(
  parameter int N_IN  = LCU_N_IN,
  parameter int N_OUT = LCU_N_OUT,
  parameter int SW    = LCU_SW,
  parameter int RW    = LCU_RW
) ();
  logic             run;
  logic [N_IN-1:0]  x;
  logic             cfg_we;
  logic [SW-1:0]    cfg_state;
  logic [RW-1:0]    cfg_rule;
  logic             cfg_valid;
  logic [N_IN-1:0]  cfg_mask;
  logic [N_IN-1:0]  cfg_val;
  logic [SW-1:0]    cfg_next;
  logic [N_OUT-1:0] cfg_out;
  logic [N_OUT-1:0] y;
  logic [SW-1:0]    state;
  logic [15:0]      trans_cnt;
  logic             wdog_trip;
  logic             cfg_err;

  modport master (
    output run, x, cfg_we, cfg_state, cfg_rule, cfg_valid, cfg_mask,
           cfg_val, cfg_next, cfg_out,
    input  y, state, trans_cnt, wdog_trip, cfg_err
  );

  modport slave (
    input  run, x, cfg_we, cfg_state, cfg_rule, cfg_valid, cfg_mask,
           cfg_val, cfg_next, cfg_out,
    output y, state, trans_cnt, wdog_trip, cfg_err
  );
endinterface

// File: rtl/lcu_rule_match.sv
// First-match priority matcher over the rule set of one state.
// Latency: combinational.
// Backpressure: none.
// Ports: rules (rule set of the present state), x (conditions) ->
// hit, next and out of the lowest-index matching rule (zeros on no hit).
module lcu_rule_match
  import lcu_pkg::*;
#(
  parameter int RULES = LCU_RULES
) (
  input  rule_t                rules [RULES],
  input  logic [LCU_N_IN-1:0]  x,
  output logic                 hit,
  output logic [LCU_SW-1:0]    next,
  output logic [LCU_N_OUT-1:0] out
);

  // Scanning from the top index down lets the lowest matching index be the
  // last one written, which gives first-match priority without a found flag.
  always_comb begin
    hit  = 1'b0;
    next = '0;
    out  = '0;
    for (int r = RULES - 1; r >= 0; r--) begin
      if (rules[r].valid && ((x & rules[r].mask) == (rules[r].val & rules[r].mask))) begin
        hit  = 1'b1;
        next = rules[r].next;
        out  = rules[r].out;
      end
    end
  end

endmodule

// File: rtl/lcu_prog.sv
// Programmable rule-table state machine: per-state first-match rules pick the
// next state and output vector; watchdog returns to INIT_STATE after a dwell.
// Latency: y same cycle (OUT_REG=0) or one cycle (OUT_REG=1); state 1 cycle.
// Backpressure: none; rule writes while running or out of range are dropped
// and flagged on cfg_err.
// Ports: clk, rst (sync, active high), bus (lcu_prog_if.slave).
module lcu_prog
  import lcu_pkg::*;
#(
  parameter int N_IN       = LCU_N_IN,
  parameter int N_OUT      = LCU_N_OUT,
  parameter int N_STATES   = LCU_N_STATES,
  parameter int RULES      = LCU_RULES,
  parameter int INIT_STATE = 0,
  parameter int OUT_REG    = 0,
  parameter int WDOG_LIMIT = 0
) (
  input logic       clk,
  input logic       rst,
  lcu_prog_if.slave bus
);

  localparam int SW = lcu_clog2(N_STATES);
  localparam int RW = lcu_clog2(RULES);
  localparam logic [SW-1:0] INIT = SW'(INIT_STATE);

  // Dwell only needs to reach WDOG_LIMIT-1: at that value the next edge
  // either changes state or trips, both of which clear it.
  localparam int DW = lcu_clog2((WDOG_LIMIT > 1) ? WDOG_LIMIT : 2);
  localparam logic [DW-1:0] LIM1 = DW'((WDOG_LIMIT > 0) ? WDOG_LIMIT - 1 : 0);

  // Rule table. Only the enable bits are reset; the data fields keep their
  // contents so a reset does not require reprogramming masks and outputs.
  logic [RULES-1:0] vld_mem  [N_STATES];
  logic [N_IN-1:0]  mask_mem [N_STATES][RULES];
  logic [N_IN-1:0]  val_mem  [N_STATES][RULES];
  logic [SW-1:0]    next_mem [N_STATES][RULES];
  logic [N_OUT-1:0] out_mem  [N_STATES][RULES];

  logic [SW-1:0] st_q;
  logic [15:0]   cnt_q;
  logic [DW-1:0] dwell_q;
  logic          trip_q;
  logic          err_q;

  logic          st_ok;
  logic [SW-1:0] st_idx;
  rule_t         cur_rules [RULES];
  logic          m_hit;
  logic [SW-1:0] m_next;
  logic [N_OUT-1:0] m_out;
  logic          fire;
  logic [SW-1:0] rule_next;
  logic [N_OUT-1:0] rule_out;
  logic          trip;
  logic [SW-1:0] nxt;
  logic          changed;
  logic          cfg_idx_ok;
  logic          cfg_wr;
  logic          cfg_bad;

  // An out-of-range state register value reads state 0's rules harmlessly;
  // st_ok then discards the result and steers the machine back to INIT.
  assign st_ok  = ({1'b0, st_q} < (SW + 1)'(N_STATES));
  assign st_idx = st_ok ? st_q : '0;

  always_comb begin
    for (int r = 0; r < RULES; r++) begin
      cur_rules[r] = '{valid: vld_mem[st_idx][r],
                       mask:  mask_mem[st_idx][r],
                       val:   val_mem[st_idx][r],
                       next:  next_mem[st_idx][r],
                       out:   out_mem[st_idx][r]};
    end
  end

  lcu_rule_match #(.RULES(RULES)) u_match (
    .rules (cur_rules),
    .x     (bus.x),
    .hit   (m_hit),
    .next  (m_next),
    .out   (m_out)
  );

  assign fire      = st_ok & m_hit;
  assign rule_next = !st_ok ? INIT : (fire ? m_next : st_q);
  assign rule_out  = fire ? m_out : '0;

  // The watchdog fires only when the rules would leave the state unchanged,
  // and also fires in INIT itself (where it changes nothing but the pulse).
  assign trip = (WDOG_LIMIT != 0) && bus.run && (dwell_q == LIM1) && (rule_next == st_q);

  assign nxt     = !bus.run ? INIT : (trip ? INIT : rule_next);
  assign changed = bus.run && (nxt != st_q);

  assign cfg_idx_ok = ({1'b0, bus.cfg_state} < (SW + 1)'(N_STATES)) &&
                      ({1'b0, bus.cfg_next}  < (SW + 1)'(N_STATES)) &&
                      ({1'b0, bus.cfg_rule}  < (RW + 1)'(RULES));
  assign cfg_wr  = bus.cfg_we && !bus.run && cfg_idx_ok;
  assign cfg_bad = bus.cfg_we && !(!bus.run && cfg_idx_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= INIT;
      cnt_q   <= '0;
      dwell_q <= '0;
      trip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q   <= nxt;
      trip_q <= trip;
      err_q  <= cfg_bad;
      if (changed && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if ((WDOG_LIMIT == 0) || !bus.run || changed || trip) begin
        dwell_q <= '0;
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_STATES; s++) begin
        vld_mem[s] <= '0;
      end
    end else if (cfg_wr) begin
      vld_mem[bus.cfg_state][bus.cfg_rule] <= bus.cfg_valid;
    end
  end

  // Reset still blocks a coincident write so the table is left untouched.
  always_ff @(posedge clk) begin
    if (cfg_wr && !rst) begin
      mask_mem[bus.cfg_state][bus.cfg_rule] <= bus.cfg_mask;
      val_mem[bus.cfg_state][bus.cfg_rule]  <= bus.cfg_val;
      next_mem[bus.cfg_state][bus.cfg_rule] <= bus.cfg_next;
      out_mem[bus.cfg_state][bus.cfg_rule]  <= bus.cfg_out;
    end
  end

  if (OUT_REG != 0) begin : g_yreg
    logic [N_OUT-1:0] y_q;
    always_ff @(posedge clk) begin
      if (rst || !bus.run || trip) begin
        y_q <= '0;
      end else begin
        y_q <= rule_out;
      end
    end
    assign bus.y = y_q;
  end else begin : g_ycomb
    assign bus.y = bus.run ? rule_out : '0;
  end

  assign bus.state     = st_q;
  assign bus.trans_cnt = cnt_q;
  assign bus.wdog_trip = trip_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: doc/lcu_prog.md
LCU_PROG -- requirements
Module: lcu_prog

Interface
REQ-001 Parameters SHALL be:
- N_IN, 15, number of condition inputs.
- N_OUT, 23, number of control outputs.
- N_STATES, 22, number of states.
- RULES, 8, number of transition rules per state.
- INIT_STATE, 0, state entered on reset, halt and watchdog trip.
- OUT_REG, 0, 0 = Mealy combinational y, 1 = registered y.
- WDOG_LIMIT, 0, dwell cycles before forced return to INIT_STATE; 0 disables the watchdog.

REQ-002 Derived widths SHALL be SW = clog2(N_STATES) and RW = clog2(RULES).

REQ-003 Ports SHALL be:
- clk  in  1  single clock; all state updates occur on its rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = execute, 0 = halt/configure.
- x  in  N_IN  condition inputs.
- cfg_we  in  1  rule write strobe.
- cfg_state  in  SW  target state of the rule write.
- cfg_rule  in  RW  target rule index of the rule write.
- cfg_valid  in  1  rule enable bit.
- cfg_mask  in  N_IN  care mask.
- cfg_val  in  N_IN  compare value.
- cfg_next  in  SW  next state.
- cfg_out  in  N_OUT  output vector asserted when the rule fires.
- y  out  N_OUT  control outputs.
- state  out  SW  present state.
- trans_cnt  out  16  saturating count of state changes.
- wdog_trip  out  1  one-cycle pulse on watchdog return.
- cfg_err  out  1  one-cycle pulse on a rejected rule write.

Function
REQ-004 Rule r of state s SHALL match when valid[s][r]=1 and (x & mask) == (val & mask).
REQ-005 The lowest-index matching rule of the present state SHALL fire; when no rule matches, the next state SHALL equal the present state and the rule output SHALL be all zeros.
REQ-006 With run=1, each rising edge SHALL load state with the next-state value produced by the priority rules of REQ-007.
REQ-007 Next-state priority SHALL be: rst > run=0 (INIT_STATE) > watchdog trip (INIT_STATE) > fired rule.
REQ-008 OUT_REG=0: y SHALL equal the fired rule's out vector combinationally in the same cycle, and SHALL be 0 when run=0.
REQ-009 OUT_REG=1: y SHALL be registered; it SHALL present the fired rule's out vector one cycle after evaluation, aligned with the state update, and SHALL be 0 after any halt, reset or trip edge.
REQ-010 trans_cnt SHALL increment on each edge where run=1 and the new state differs from the old state, including watchdog returns; it SHALL saturate at 16'hFFFF.
REQ-011 A dwell counter SHALL increment on each run=1 edge where the state is unchanged, and SHALL clear on a state change or when run=0.
REQ-012 When WDOG_LIMIT != 0, dwell == WDOG_LIMIT-1 and no rule changes the state, the next edge SHALL force INIT_STATE, clear dwell and set wdog_trip=1 for exactly one cycle; this SHALL also apply when the present state is already INIT_STATE.
REQ-013 cfg_we=1 with run=0 and cfg_state < N_STATES and cfg_next < N_STATES SHALL write the rule; the written rule SHALL be effective from the next cycle.
REQ-014 cfg_we=1 with run=1, or with any index out of range, SHALL leave the rule table unchanged and set cfg_err=1 for one cycle.
REQ-015 A state register value >= N_STATES is unreachable; the next state from such a value SHALL be INIT_STATE.

Reset
REQ-016 rst=1 at an edge SHALL set state=INIT_STATE, trans_cnt=0, dwell=0, wdog_trip=0, cfg_err=0, registered y=0, and every rule valid bit to 0.
REQ-017 Rule mask, value, next and out fields SHALL be unaffected by reset.
REQ-018 rst SHALL take priority over simultaneous cfg_we and run.

Structure
REQ-019 Package lcu_pkg SHALL hold the rule record typedef (valid, mask, val, next, out) and a width helper function for SW and RW.
REQ-020 The per-state first-match priority matcher SHALL be a combinational sub-module named lcu_rule_match.

Verification
REQ-021 Reset, then run=1 with an empty table and arbitrary x -> state=0, y=0, trans_cnt=0 on every cycle.
REQ-022 Program state0/rule0 (mask=0x4001, val=0x4001, next=1, out=0x000006) and rule1 (mask=0x4000, val=0x0000, next=2, out=0x000001); run with x=0x4001 -> y=0x000006 in the same cycle (OUT_REG=0) and state=1 after the edge; repeat from state0 with x=0x0000 -> y=0x000001 and state=2.
REQ-023 Set OUT_REG=1 and repeat REQ-022 -> y=0x000006 appears one cycle later, aligned with state=1.
REQ-024 Set WDOG_LIMIT=4, move to state 3 with no matching rule -> after 4 dwell cycles state=0, wdog_trip high for exactly 1 cycle, trans_cnt incremented by 1.
REQ-025 Assert cfg_we with run=1, then assert cfg_we with cfg_next=25 while run=0 -> cfg_err pulses both times and table readback behaviour is unchanged.
REQ-026 Preload trans_cnt to 0xFFFE via a ping-pong rule pair, run 3 transitions -> trans_cnt holds 0xFFFF.
